// File: rtl/sparse_dispatcher_if.sv
// Signal bundle linking the sparse dispatcher to its requester, the sparse word memory
// and the accumulation controller.
interface sparse_dispatcher_if #(parameter int WORD_WIDTH = 32);
  logic                  start;
  logic [5:0]            num_words;
  logic [9:0]            sparse_mem_addr_o;
  logic [WORD_WIDTH-1:0] sparse_mem_data_i;
  logic                  ctrl_start_o;
  logic                  ctrl_busy_i;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [1:0]            err_code;
  logic [5:0]            words_done;
  logic [2:0]            state_dbg;

  // Handshakes: start is taken only on a rising edge where busy=0 (it is ignored otherwise);
  // ctrl_start_o is a one-cycle request, the controller acknowledges by raising ctrl_busy_i
  // and signals completion by dropping it; done is a one-cycle pulse coinciding with busy=0.
  modport master (
    output start, num_words, sparse_mem_data_i, ctrl_busy_i,
    input  sparse_mem_addr_o, ctrl_start_o, busy, done, err, err_code, words_done, state_dbg
  );
  modport slave (
    input  start, num_words, sparse_mem_data_i, ctrl_busy_i,
    output sparse_mem_addr_o, ctrl_start_o, busy, done, err, err_code, words_done, state_dbg
  );
endinterface

// File: rtl/sparse_dispatcher.sv
// Walks a sparse word list, validates each {high, low} bit-position pair and hands valid
// words one at a time to the accumulation controller, guarded by a watchdog.
module sparse_dispatcher #(
  parameter int WORD_WIDTH      = 32,
  parameter int MEM_SIZE        = 553,
  parameter int MEM_SPARSE_SIZE = 50,
  parameter int MAX_DIFF        = 17,
  parameter int TIMEOUT         = 4095
) (
  input logic                clk,
  input logic                rst,
  sparse_dispatcher_if.slave bus
);
  localparam int          POS_LIMIT = MEM_SIZE * 32;
  localparam logic [11:0] ACK_LAST  = 12'd3;
  localparam logic [11:0] DONE_LAST = 12'(TIMEOUT - 1);
  localparam logic [11:0] WD_MAX    = 12'hFFF;
  localparam logic [5:0]  N_MAX     = 6'(MEM_SPARSE_SIZE);

  typedef enum logic [2:0] {
    IDLE, FETCH, CHECK, LAUNCH, WAIT_ACK, WAIT_DONE, FINISH
  } state_t;

  state_t      state, state_next;
  logic [5:0]  n, n_next, idx, idx_next, words, words_next, n_clamp;
  logic [9:0]  addr, addr_next;
  logic [11:0] wd, wd_next;
  logic        busy_q, busy_next, done_q, done_next, start_q, start_next;
  logic        err_q, err_next, busy_prev;
  logic [1:0]  code_q, code_next;

  logic [15:0] high, low;
  logic [10:0] high_blk, low_blk;
  logic        terminator, bad_word;

  assign high       = bus.sparse_mem_data_i[31:16];
  assign low        = bus.sparse_mem_data_i[15:0];
  assign high_blk   = high[15:5];
  assign low_blk    = low[15:5];
  assign terminator = (bus.sparse_mem_data_i[31:0] == 32'hFFFF_FFFF);
  // The block-distance term only matters when low>=high; otherwise low<high already flags it.
  assign bad_word   = ({16'd0, high} >= 32'(POS_LIMIT)) || ({16'd0, low} >= 32'(POS_LIMIT)) ||
                      (low < high) || ({21'd0, low_blk - high_blk} > 32'(MAX_DIFF));
  assign n_clamp    = (bus.num_words > N_MAX) ? N_MAX : bus.num_words;

  always_comb begin
    state_next = state;
    n_next     = n;
    idx_next   = idx;
    words_next = words;
    addr_next  = addr;
    busy_next  = busy_q;
    done_next  = 1'b0;
    start_next = 1'b0;
    err_next   = err_q;
    code_next  = code_q;
    case (state)
      IDLE: begin
        if (bus.start && !busy_q) begin
          n_next     = n_clamp;
          idx_next   = '0;
          words_next = '0;
          err_next   = 1'b0;
          code_next  = 2'd0;
          busy_next  = 1'b1;
          state_next = (n_clamp == 6'd0) ? FINISH : FETCH;
        end
      end
      FETCH: state_next = CHECK;
      CHECK: begin
        if (terminator) begin
          state_next = FINISH;
        end else if (bad_word) begin
          err_next   = 1'b1;
          code_next  = 2'd1;
          state_next = FINISH;
        end else begin
          state_next = LAUNCH;
        end
      end
      LAUNCH: state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.ctrl_busy_i) begin
          state_next = WAIT_DONE;
        end else if (wd == ACK_LAST) begin
          err_next   = 1'b1;
          code_next  = 2'd2;
          state_next = FINISH;
        end
      end
      WAIT_DONE: begin
        if (busy_prev && !bus.ctrl_busy_i) begin
          words_next = words + 6'd1;
          if (idx + 6'd1 == n) begin
            state_next = FINISH;
          end else begin
            idx_next   = idx + 6'd1;
            state_next = FETCH;
          end
        end else if (wd == DONE_LAST) begin
          err_next   = 1'b1;
          code_next  = 2'd3;
          state_next = FINISH;
        end
      end
      FINISH: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Outputs are registered so they line up with the state they belong to.
    if (state_next == FETCH) addr_next = 10'(idx_next);
    if (state_next == LAUNCH) start_next = 1'b1;
    if (state_next != state) wd_next = '0;
    else if (wd == WD_MAX)   wd_next = wd;
    else                     wd_next = wd + 12'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      idx       <= '0;
      words     <= '0;
      addr      <= '0;
      wd        <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'd0;
      busy_prev <= 1'b0;
    end else begin
      state     <= state_next;
      n         <= n_next;
      idx       <= idx_next;
      words     <= words_next;
      addr      <= addr_next;
      wd        <= wd_next;
      busy_q    <= busy_next;
      done_q    <= done_next;
      start_q   <= start_next;
      err_q     <= err_next;
      code_q    <= code_next;
      busy_prev <= bus.ctrl_busy_i;
    end
  end

  assign bus.sparse_mem_addr_o = addr;
  assign bus.ctrl_start_o      = start_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.err               = err_q;
  assign bus.err_code          = code_q;
  assign bus.words_done        = words;
  assign bus.state_dbg         = state;
endmodule

// File: tb/tb_sparse_dispatcher.sv
// Directed bench for sparse_dispatcher: memory and controller models, a list-level
// expectation model, and a per-cycle compare process.
module tb_sparse_dispatcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sparse_dispatcher_if #(.WORD_WIDTH(32)) bus ();
  sparse_dispatcher dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [0:1023];
  int ctrl_mode = 0;
  int busy_len  = 20;
  int busy_cnt  = 0;

  // Synchronous sparse memory, one-cycle read latency.
  always @(posedge clk) bus.sparse_mem_data_i <= mem[bus.sparse_mem_addr_o];

  // Controller: mode 0 busy for busy_len cycles, 1 never busy, 2 stuck busy.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ctrl_busy_i <= 1'b0;
      busy_cnt        <= 0;
    end else begin
      case (ctrl_mode)
        0: begin
          if (bus.ctrl_start_o) begin
            bus.ctrl_busy_i <= 1'b1;
            busy_cnt        <= busy_len - 1;
          end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
          else bus.ctrl_busy_i <= 1'b0;
        end
        1:       bus.ctrl_busy_i <= 1'b0;
        default: if (bus.ctrl_start_o) bus.ctrl_busy_i <= 1'b1;
      endcase
    end
  end

  // Scoreboard
  logic [9:0] exp_q[$];
  int   exp_words;
  logic exp_err;
  logic [1:0] exp_code;
  int checks = 0, errors = 0;
  int done_seen = 0, n_launch = 0;
  bit first_launch = 1'b0, poke = 1'b0;
  time t_start = 0, t_launch = 0, t_done = 0, t_err = 0, t_busy_fall = 0;
  logic prev_start = 1'b0, prev_done = 1'b0, prev_busy_i = 1'b0, prev_err = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cycles(input time a, input time b);
    return int'((b - a) / 10);
  endfunction

  // List-level expectation: which addresses get launched and how the run ends.
  task automatic model(input int nw, input int mode);
    int n, hi, lo;
    logic [31:0] w;
    exp_q.delete();
    exp_words = 0;
    exp_err   = 1'b0;
    exp_code  = 2'd0;
    n = (nw > 50) ? 50 : nw;
    for (int i = 0; i < n; i++) begin
      w  = mem[i];
      hi = int'(w[31:16]);
      lo = int'(w[15:0]);
      if (w == 32'hFFFF_FFFF) break;
      if (hi >= 17696 || lo >= 17696 || lo < hi || (lo / 32 - hi / 32) > 17) begin
        exp_err = 1'b1; exp_code = 2'd1; break;
      end
      exp_q.push_back(10'(i));
      if (mode == 1) begin exp_err = 1'b1; exp_code = 2'd2; break; end
      if (mode == 2) begin exp_err = 1'b1; exp_code = 2'd3; break; end
      exp_words++;
    end
  endtask

  // Compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0; prev_done = 1'b0; prev_busy_i = 1'b0; prev_err = 1'b0;
    end else begin
      if (bus.ctrl_start_o) begin
        check("start_single_cycle", prev_start, 0);
        check("start_while_busy", bus.busy, 1);
        check("launch_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("launch_addr", bus.sparse_mem_addr_o, exp_q.pop_front());
        if (first_launch) check("first_launch_latency", cycles(t_start, $time), 3);
        else              check("inter_word_gap", cycles(t_busy_fall, $time), 3);
        first_launch = 1'b0;
        t_launch = $time;
        n_launch++;
      end
      if (bus.done) begin
        done_seen++;
        t_done = $time;
        check("done_single_cycle", prev_done, 0);
        check("words_done", bus.words_done, exp_words);
        check("err", bus.err, exp_err);
        check("err_code", bus.err_code, exp_code);
        check("busy_at_done", bus.busy, 0);
        check("launches_left", exp_q.size(), 0);
      end
      if (bus.err && !prev_err) t_err = $time;
      if (prev_busy_i && !bus.ctrl_busy_i) t_busy_fall = $time;
      prev_start  = bus.ctrl_start_o;
      prev_done   = bus.done;
      prev_busy_i = bus.ctrl_busy_i;
      prev_err    = bus.err;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_addr", bus.sparse_mem_addr_o, 0);
    check("rst_words_done", bus.words_done, 0);
    rst = 1'b0;
  endtask

  task automatic run(input int nw, input int mode, input int len, input int exp_done_cyc,
                     input bit rst_first);
    int d0;
    if (rst_first) do_reset();
    model(nw, mode);
    ctrl_mode    = mode;
    busy_len     = len;
    first_launch = 1'b1;
    n_launch     = 0;
    t_err        = 0;
    d0           = done_seen;
    @(negedge clk);
    bus.num_words = 6'(nw);
    bus.start     = 1'b1;
    t_start       = $time;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    for (int i = 0; i < 20000 && done_seen == d0; i++) begin
      @(negedge clk);
      if (poke && i == 10) begin bus.start = 1'b1; bus.num_words = 6'd1; end
      if (poke && i == 11) bus.start = 1'b0;
      #1;
    end
    check("done_within_budget", done_seen - d0, 1);
    if (exp_done_cyc >= 0) check("done_latency", cycles(t_start, t_done), exp_done_cyc);
    @(negedge clk);
    check("done_pulse_ends", bus.done, 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.num_words = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    // Three valid words, one mid-run start that must be ignored.
    mem[0] = 32'h0040_0100; mem[1] = 32'h0000_0020; mem[2] = 32'h1000_1200;
    model(3, 0);
    check("model_pin_t1_words", exp_words, 3);
    poke = 1'b1;
    run(3, 0, 20, -1, 1'b1);
    poke = 1'b0;
    check("t1_launches", n_launch, 3);
    check("t1_words_done_lit", bus.words_done, 3);
    check("t1_err_lit", bus.err, 0);

    // Terminator at word 1.
    mem[1] = 32'hFFFF_FFFF;
    run(5, 0, 20, -1, 1'b1);
    check("t2_launches", n_launch, 1);
    check("t2_words_done_lit", bus.words_done, 1);

    // Zero-length list: no read, address left where the last run put it.
    run(0, 0, 20, 2, 1'b0);
    check("t6_launches", n_launch, 0);
    check("t6_addr_unchanged", bus.sparse_mem_addr_o, 1);

    // Bad words: low<high, then block distance 18.
    mem[0] = 32'h0200_0100;
    run(3, 0, 20, 4, 1'b1);
    check("t3a_err_time", cycles(t_start, t_err), 3);
    check("t3a_code_lit", bus.err_code, 1);
    check("t3a_launches", n_launch, 0);
    mem[0] = 32'h0000_0240;
    model(3, 0);
    check("model_pin_t3b_code", exp_code, 1);
    run(3, 0, 20, 4, 1'b1);
    check("t3b_code_lit", bus.err_code, 1);
    check("t3b_launches", n_launch, 0);

    // Boundaries: distance exactly 17, positions 17695 valid, low=17696 rejected.
    mem[0] = 32'h0000_0220; mem[1] = 32'h451F_451F; mem[2] = 32'h4500_4520;
    run(3, 0, 4, -1, 1'b1);
    check("t9_launches", n_launch, 2);
    check("t9_words_done_lit", bus.words_done, 2);
    check("t9_code_lit", bus.err_code, 1);

    // Acknowledge timeout.
    mem[0] = 32'h0040_0100;
    run(3, 1, 20, -1, 1'b1);
    check("t4_err_after_launch", cycles(t_launch, t_err), 5);
    check("t4_done_after_err", cycles(t_err, t_done), 1);
    check("t4_code_lit", bus.err_code, 2);

    // Completion timeout with the controller stuck busy.
    run(3, 2, 20, -1, 1'b1);
    check("t5_err_after_launch", cycles(t_launch, t_err), 4097);
    check("t5_done_after_err", cycles(t_err, t_done), 1);
    check("t5_code_lit", bus.err_code, 3);

    // num_words=63 clamps to 50; words past 50 are bad so overrun would show.
    for (int i = 0; i < 50; i++) mem[i] = 32'h0000_0020;
    for (int i = 50; i < 64; i++) mem[i] = 32'h0200_0100;
    model(63, 0);
    check("model_pin_t7_launches", exp_q.size(), 50);
    run(63, 0, 2, -1, 1'b1);
    check("t7_launches", n_launch, 50);
    check("t7_words_done_lit", bus.words_done, 50);
    check("t7_err_lit", bus.err, 0);

    // Reset during WAIT_DONE, then a clean run from address 0.
    mem[0] = 32'h0040_0100; mem[1] = 32'h0000_0020; mem[2] = 32'h1000_1200;
    do_reset();
    model(3, 0);
    ctrl_mode = 0; busy_len = 20; first_launch = 1'b1;
    @(negedge clk);
    bus.num_words = 6'd3; bus.start = 1'b1; t_start = $time;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 200 && !bus.ctrl_busy_i; i++) @(negedge clk);
    check("t8_ctrl_busy_seen", bus.ctrl_busy_i, 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t8_rst_busy", bus.busy, 0);
    check("t8_rst_done", bus.done, 0);
    check("t8_rst_err", bus.err, 0);
    check("t8_rst_code", bus.err_code, 0);
    check("t8_rst_start", bus.ctrl_start_o, 0);
    check("t8_rst_addr", bus.sparse_mem_addr_o, 0);
    check("t8_rst_words", bus.words_done, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run(3, 0, 20, -1, 1'b0);
    check("t8_launches", n_launch, 3);
    check("t8_words_done_lit", bus.words_done, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
